// File: rtl/mandel_pkg.sv
// Shared types and Q-format constants for the Mandelbrot escape-time engine
// and the pixel coordinate generator.
`timescale 1ns/1ps
package mandel_pkg;

    localparam int COORD_WIDTH_DEF      = 32;
    localparam int FRAC_BITS_DEF        = 28;
    localparam int ITERATIONS_WIDTH_DEF = 6;
    localparam int MAX_ITERATION_DEF    = 50;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // One guard bit above the shifted product width so zr^2 + zi^2 cannot wrap.
    function automatic int sum_width(input int coord_width, input int frac_bits);
        return 2 * coord_width - frac_bits + 1;
    endfunction

    localparam int SUM_WIDTH_DEF = sum_width(COORD_WIDTH_DEF, FRAC_BITS_DEF);

    function automatic logic [127:0] escape_limit(input int frac_bits);
        return 128'd4 << frac_bits;
    endfunction

endpackage

// File: rtl/mandel_step.sv
// One combinational z <- z^2 + c step with the |z|^2 > 4 escape test.
`timescale 1ns/1ps
module mandel_step
    import mandel_pkg::*;
#(
    parameter int COORD_WIDTH = COORD_WIDTH_DEF,
    parameter int FRAC_BITS   = FRAC_BITS_DEF
) (
    input  logic signed [COORD_WIDTH-1:0] zr,
    input  logic signed [COORD_WIDTH-1:0] zi,
    input  logic signed [COORD_WIDTH-1:0] c_re,
    input  logic signed [COORD_WIDTH-1:0] c_im,
    output logic signed [COORD_WIDTH-1:0] zr_next,
    output logic signed [COORD_WIDTH-1:0] zi_next,
    output logic                          escape
);

    localparam int PW = 2 * COORD_WIDTH;
    localparam int SW = sum_width(COORD_WIDTH, FRAC_BITS);
    localparam logic signed [SW-1:0] LIMIT = SW'(escape_limit(FRAC_BITS));

    logic signed [PW-1:0] zr_sq_full;
    logic signed [PW-1:0] zi_sq_full;
    logic signed [PW-1:0] zrzi_full;
    logic signed [PW-1:0] zr_sq;
    logic signed [PW-1:0] zi_sq;
    logic signed [PW-1:0] zrzi;
    logic signed [SW-1:0] mag_sq;

    assign zr_sq_full = PW'(zr) * PW'(zr);
    assign zi_sq_full = PW'(zi) * PW'(zi);
    assign zrzi_full  = PW'(zr) * PW'(zi);

    assign zr_sq = zr_sq_full >>> FRAC_BITS;
    assign zi_sq = zi_sq_full >>> FRAC_BITS;
    assign zrzi  = zrzi_full  >>> FRAC_BITS;

    // Squares are non-negative after the floor shift, so a signed compare is exact.
    assign mag_sq = SW'(zr_sq) + SW'(zi_sq);
    assign escape = mag_sq > LIMIT;

    // Truncation is safe: only committed when |z| <= 2 and |c| <= 2.
    assign zr_next = COORD_WIDTH'(zr_sq - zi_sq + PW'(c_re));
    assign zi_next = COORD_WIDTH'((zrzi <<< 1) + PW'(c_im));

endmodule

// File: rtl/mandelbrot_engine.sv
// Escape-time iteration engine: accepts c, iterates one step per clock,
// returns the iteration count over a valid/ready handshake.
`timescale 1ns/1ps
module mandelbrot_engine
    import mandel_pkg::*;
#(
    parameter int COORD_WIDTH      = COORD_WIDTH_DEF,
    parameter int FRAC_BITS        = FRAC_BITS_DEF,
    parameter int ITERATIONS_WIDTH = ITERATIONS_WIDTH_DEF,
    parameter int MAX_ITERATION    = MAX_ITERATION_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [COORD_WIDTH-1:0] c_re,
    input  logic signed [COORD_WIDTH-1:0] c_im,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [ITERATIONS_WIDTH-1:0]   iterations,
    output logic                          out_valid,
    input  logic                          out_ready
);

    // state | meaning
    // IDLE  | waiting for c (in_ready high once out of reset)
    // ITER  | one escape test / z update per cycle
    // DONE  | result presented on iterations, waiting for out_ready

    localparam logic [ITERATIONS_WIDTH-1:0] MAX_IT = ITERATIONS_WIDTH'(MAX_ITERATION);

    state_t                        state, state_next;
    logic                          in_ready_next;
    logic [ITERATIONS_WIDTH-1:0]   iterations_next;
    logic [ITERATIONS_WIDTH-1:0]   count, count_next;
    logic signed [COORD_WIDTH-1:0] zr, zr_next;
    logic signed [COORD_WIDTH-1:0] zi, zi_next;
    logic signed [COORD_WIDTH-1:0] cr, cr_next;
    logic signed [COORD_WIDTH-1:0] ci, ci_next;
    logic signed [COORD_WIDTH-1:0] step_zr;
    logic signed [COORD_WIDTH-1:0] step_zi;
    logic                          step_escape;

    mandel_step #(
        .COORD_WIDTH (COORD_WIDTH),
        .FRAC_BITS   (FRAC_BITS)
    ) u_step (
        .zr      (zr),
        .zi      (zi),
        .c_re    (cr),
        .c_im    (ci),
        .zr_next (step_zr),
        .zi_next (step_zi),
        .escape  (step_escape)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            iterations <= '0;
            count      <= '0;
            zr         <= '0;
            zi         <= '0;
            cr         <= '0;
            ci         <= '0;
        end else begin
            state      <= state_next;
            in_ready   <= in_ready_next;
            iterations <= iterations_next;
            count      <= count_next;
            zr         <= zr_next;
            zi         <= zi_next;
            cr         <= cr_next;
            ci         <= ci_next;
        end
    end

    always_comb begin
        state_next      = state;
        iterations_next = iterations;
        count_next      = count;
        zr_next         = zr;
        zi_next         = zi;
        cr_next         = cr;
        ci_next         = ci;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    cr_next    = c_re;
                    ci_next    = c_im;
                    zr_next    = '0;
                    zi_next    = '0;
                    count_next = '0;
                    state_next = ITER;
                end
            end
            ITER: begin
                if (count == MAX_IT) begin
                    iterations_next = MAX_IT;
                    state_next      = DONE;
                end else if (step_escape) begin
                    iterations_next = count;
                    state_next      = DONE;
                end else begin
                    zr_next    = step_zr;
                    zi_next    = step_zi;
                    count_next = count + ITERATIONS_WIDTH'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Registered so in_ready stays low until the first edge after reset release.
        in_ready_next = (state_next == IDLE);
    end

    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_mandelbrot_engine.sv
// Self-checking bench for mandelbrot_engine: directed table, handshake and
// reset corner cases, and randomized c against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_mandelbrot_engine;
    import mandel_pkg::*;

    localparam int CW   = 32;
    localparam int FB   = 28;
    localparam int IW   = 6;
    localparam int MAXI = 50;
    localparam int ONE  = 1 << FB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] c_re = '0;
    logic [CW-1:0] c_im = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] iterations;
    logic          out_valid;
    logic          out_ready = 1'b1;

    int total = 0;
    int bad   = 0;

    mandelbrot_engine #(
        .COORD_WIDTH      (CW),
        .FRAC_BITS        (FB),
        .ITERATIONS_WIDTH (IW),
        .MAX_ITERATION    (MAXI)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .c_re       (c_re),
        .c_im       (c_im),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .iterations (iterations),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cr;
        int    ci;
        int    n;
        string name;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Escape-time count computed directly from the arithmetic rules.
    function automatic int model_iter(input longint cr, input longint ci);
        longint zr = 0;
        longint zi = 0;
        longint a, b, p;
        for (int n = 0; n < MAXI; n++) begin
            a = (zr * zr) >>> FB;
            b = (zi * zi) >>> FB;
            p = (zr * zi) >>> FB;
            if (a + b > (longint'(4) <<< FB)) return n;
            zr = longint'(int'(a - b + cr));
            zi = longint'(int'(2 * p + ci));
        end
        return MAXI;
    endfunction

    // Latency is counted in edges from the edge before the accept cycle.
    task automatic run_job(input int cr, input int ci, input int exp_n, input int hold,
                           input bit keep_valid, input string name);
        int budget;
        int lat;
        budget = 0;
        while (in_ready !== 1'b1 && budget < 20) begin
            step();
            budget++;
        end
        if (in_ready !== 1'b1) begin
            check({name, "_in_ready_wait"}, 0, 1);
            return;
        end
        out_ready = (hold == 0);
        c_re      = cr;
        c_im      = ci;
        in_valid  = 1'b1;
        step();
        lat = 1;
        if (keep_valid) begin
            c_re = '0;
            c_im = '0;
        end else begin
            in_valid = 1'b0;
        end
        check({name, "_in_ready_busy"}, in_ready, 0);
        while (out_valid !== 1'b1 && lat < 2 * MAXI) begin
            step();
            lat++;
        end
        in_valid = 1'b0;
        if (out_valid !== 1'b1) begin
            check({name, "_out_valid_timeout"}, 0, 1);
            out_ready = 1'b1;
            return;
        end
        check({name, "_iterations"}, iterations, exp_n);
        check({name, "_latency"}, lat, exp_n + 2);
        for (int i = 0; i < hold; i++) begin
            step();
            check({name, "_hold_iterations"}, iterations, exp_n);
            check({name, "_hold_in_ready"}, in_ready, 0);
            check({name, "_hold_out_valid"}, out_valid, 1);
        end
        out_ready = 1'b1;
        step();
        check({name, "_in_ready_after"}, in_ready, 1);
        check({name, "_out_valid_after"}, out_valid, 0);
    endtask

    initial begin
        int cr, ci;
        vecs[0] = '{cr: 0,       ci: 0,   n: 50, name: "c_zero"};
        vecs[1] = '{cr: ONE,     ci: 0,   n: 3,  name: "c_one"};
        vecs[2] = '{cr: -2*ONE,  ci: 0,   n: 50, name: "c_minus_two"};
        vecs[3] = '{cr: ONE/2,   ci: 0,   n: 5,  name: "c_half"};
        vecs[4] = '{cr: 0,       ci: ONE, n: 50, name: "c_i"};

        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_iterations", iterations, 0);
        #10;
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_before_edge", in_ready, 0);
        step();
        check("rel_in_ready_after_edge", in_ready, 1);

        foreach (vecs[i]) run_job(vecs[i].cr, vecs[i].ci, vecs[i].n, 0, 1'b0, vecs[i].name);

        run_job(ONE, 0, 3, 10, 1'b1, "hold_c_one");

        foreach (vecs[i]) run_job(vecs[i].cr, vecs[i].ci, vecs[i].n, 0, 1'b0, {"b2b_", vecs[i].name});

        for (int k = 0; k < 25; k++) begin
            cr = int'($urandom_range(0, 32'd1 << 30)) - (1 << 29);
            ci = int'($urandom_range(0, 32'd1 << 30)) - (1 << 29);
            run_job(cr, ci, model_iter(cr, ci), int'($urandom_range(0, 2)), 1'b0, "rand");
        end

        run_job(ONE, 0, 3, 0, 1'b0, "pre_reset");
        c_re     = '0;
        c_im     = '0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        check("mid_iter_out_valid", out_valid, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_iterations", iterations, 0);
        check("async_rst_in_ready", in_ready, 0);
        #10;
        rst_n = 1'b1;
        check("rerel_in_ready_before_edge", in_ready, 0);
        step();
        check("rerel_in_ready", in_ready, 1);
        check("rerel_out_valid", out_valid, 0);
        run_job(ONE, 0, 3, 0, 1'b0, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
